regif_rw_acc: RTL and testbench

- Parametrised successor to the host register-write accessor: executes one host-initiated register access at a time, either read or write, on the REGIF master bus.
- Sits between tlp2regif (request side) and regif2tlp (response side), behind the REGIF arbiter.
- Adds read support, per-access byte enables, a bus timeout with its own response code, configurable synchroniser depth, and protection against double acceptance of one request.

---
 rtl/regif_rw_acc_if.sv | 26 ++
 rtl/regif_rw_acc.sv | 270 +++++++++++++++++++++++++++
 tb/tb_regif_rw_acc.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/regif_rw_acc_if.sv
// REGIF master bus: request/address/data from the accessor, command/data handshakes back from the bus.
interface regif_rw_acc_if;
  logic        IP2Bus_MstRd_Req;
  logic        IP2Bus_MstWr_Req;
  logic [31:0] IP2Bus_Mst_Addr;
  logic [3:0]  IP2Bus_Mst_BE;
  logic [31:0] IP2Bus_MstWr_d;
  logic        Bus2IP_Mst_CmdAck;
  logic        Bus2IP_Mst_Cmplt;
  logic        Bus2IP_Mst_Error;
  logic        Bus2IP_MstWr_dst_rdy_n;
  logic [31:0] Bus2IP_MstRd_d;
  logic        Bus2IP_MstRd_src_rdy_n;

  modport master (
    output IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE, IP2Bus_MstWr_d,
    input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error, Bus2IP_MstWr_dst_rdy_n,
           Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n
  );

  modport slave (
    input  IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE, IP2Bus_MstWr_d,
    output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error, Bus2IP_MstWr_dst_rdy_n,
           Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n
  );
endinterface

// File: rtl/regif_rw_acc.sv
// Single-outstanding host register accessor: one read or write on the REGIF master bus per request,
// with timeout, byte enables and a drain state that blocks re-acceptance of a still-high request.
module regif_rw_acc #(
  parameter logic [31:0] ACK_CODE       = 32'h1,
  parameter logic [31:0] NACK_CODE      = 32'h2,
  parameter logic [31:0] TOUT_CODE      = 32'h3,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          SYNC_STAGES    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           acc_addr,
  input  logic [31:0]           acc_data,
  input  logic [3:0]            acc_be,
  input  logic                  acc_wr,
  input  logic                  acc_en,
  output logic                  acc_en_ack,
  regif_rw_acc_if.master        bus,
  output logic                  snd_resp,
  input  logic                  snd_resp_ack,
  output logic [63:0]           resp,
  input  logic                  my_regif,
  output logic                  drv_regif
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_ISSUE = 3'd2,
    S_BUSY  = 3'd3,
    S_RESP  = 3'd4,
    S_HSK   = 3'd5,
    S_DRAIN = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d, ack_sync_q, ack_sync_d;
  logic                   acc_en_ack_q, acc_en_ack_d;
  logic                   rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic [31:0]            mst_addr_q, mst_addr_d, mst_wdata_q, mst_wdata_d;
  logic [3:0]             mst_be_q, mst_be_d;
  logic [31:0]            cap_addr_q, cap_addr_d, cap_data_q, cap_data_d;
  logic [3:0]             cap_be_q, cap_be_d;
  logic                   cap_wr_q, cap_wr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d, tout_q, tout_d;
  logic                   wdone_q, wdone_d, rdone_q, rdone_d, cmplt_q, cmplt_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   drv_q, drv_d, snd_resp_q, snd_resp_d;
  logic [63:0]            resp_q, resp_d;
  logic                   en_s, ack_s;
  logic                   wdone_now_s, rdone_now_s, cmplt_now_s;

  assign en_s  = en_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // Shift the asynchronous request and response-ack levels through the synchroniser chains.
  always_comb begin
    en_sync_d     = en_sync_q;
    ack_sync_d    = ack_sync_q;
    en_sync_d[0]  = acc_en;
    ack_sync_d[0] = snd_resp_ack;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      en_sync_d[i]  = en_sync_q[i-1];
      ack_sync_d[i] = ack_sync_q[i-1];
    end
  end

  // Completion terms include this cycle's bus pulses so Cmplt and data may coincide.
  always_comb begin
    wdone_now_s = wdone_q | (cap_wr_q & ~bus.Bus2IP_MstWr_dst_rdy_n);
    rdone_now_s = rdone_q | (~cap_wr_q & ~bus.Bus2IP_MstRd_src_rdy_n);
    cmplt_now_s = cmplt_q | bus.Bus2IP_Mst_Cmplt;
  end

  // Access state machine; every output is registered from its _d term.
  always_comb begin
    state_d      = state_q;
    acc_en_ack_d = 1'b0;
    rd_req_d     = rd_req_q;
    wr_req_d     = wr_req_q;
    mst_addr_d   = mst_addr_q;
    mst_be_d     = mst_be_q;
    mst_wdata_d  = mst_wdata_q;
    cap_addr_d   = cap_addr_q;
    cap_data_d   = cap_data_q;
    cap_be_d     = cap_be_q;
    cap_wr_d     = cap_wr_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    tout_d       = tout_q;
    wdone_d      = wdone_q;
    rdone_d      = rdone_q;
    cmplt_d      = cmplt_q;
    rdata_d      = rdata_q;
    drv_d        = drv_q;
    snd_resp_d   = snd_resp_q;
    resp_d       = resp_q;
    case (state_q)
      S_IDLE: begin
        cap_addr_d = acc_addr;
        cap_data_d = acc_data;
        cap_be_d   = acc_be;
        cap_wr_d   = acc_wr;
        if (en_s) begin
          acc_en_ack_d = 1'b1;
          state_d      = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (my_regif) begin
          drv_d   = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_GRANT;
        end
      end
      S_ISSUE: begin
        mst_addr_d  = cap_addr_q;
        mst_be_d    = cap_be_q;
        mst_wdata_d = cap_data_q;
        wr_req_d    = cap_wr_q;
        rd_req_d    = ~cap_wr_q;
        cnt_d       = '0;
        err_d       = 1'b0;
        tout_d      = 1'b0;
        wdone_d     = 1'b0;
        rdone_d     = 1'b0;
        cmplt_d     = 1'b0;
        state_d     = S_BUSY;
      end
      S_BUSY: begin
        cnt_d   = cnt_q + CNT_W'(1);
        wdone_d = wdone_now_s;
        rdone_d = rdone_now_s;
        cmplt_d = cmplt_now_s;
        if (bus.Bus2IP_Mst_CmdAck) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
        end else begin
          rd_req_d = rd_req_q;
          wr_req_d = wr_req_q;
        end
        if (~cap_wr_q && ~bus.Bus2IP_MstRd_src_rdy_n) begin
          rdata_d = bus.Bus2IP_MstRd_d;
        end else begin
          rdata_d = rdata_q;
        end
        if (bus.Bus2IP_Mst_Cmplt && bus.Bus2IP_Mst_Error) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (cmplt_now_s && (wdone_now_s || rdone_now_s)) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2)) begin
          // Counter is about to reach TIMEOUT_CYCLES-1: abort the bus access.
          tout_d   = 1'b1;
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          state_d  = S_RESP;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_RESP: begin
        if (tout_q) begin
          resp_d = {TOUT_CODE, 32'h0000_0000};
        end else if (err_q) begin
          resp_d = {NACK_CODE, (cap_wr_q ? cap_data_q : rdata_q)};
        end else begin
          resp_d = {ACK_CODE, (cap_wr_q ? cap_data_q : rdata_q)};
        end
        drv_d      = 1'b0;
        snd_resp_d = 1'b1;
        state_d    = S_HSK;
      end
      S_HSK: begin
        if (ack_s) begin
          snd_resp_d = 1'b0;
          state_d    = S_DRAIN;
        end else begin
          state_d = S_HSK;
        end
      end
      S_DRAIN: begin
        if (!en_s && !ack_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d    = S_IDLE;
        rd_req_d   = 1'b0;
        wr_req_d   = 1'b0;
        drv_d      = 1'b0;
        snd_resp_d = 1'b0;
      end
    endcase
  end

  // All state, captures and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      en_sync_q    <= '0;
      ack_sync_q   <= '0;
      acc_en_ack_q <= 1'b0;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      mst_addr_q   <= 32'h0;
      mst_be_q     <= 4'h0;
      mst_wdata_q  <= 32'h0;
      cap_addr_q   <= 32'h0;
      cap_data_q   <= 32'h0;
      cap_be_q     <= 4'h0;
      cap_wr_q     <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      tout_q       <= 1'b0;
      wdone_q      <= 1'b0;
      rdone_q      <= 1'b0;
      cmplt_q      <= 1'b0;
      rdata_q      <= 32'h0;
      drv_q        <= 1'b0;
      snd_resp_q   <= 1'b0;
      resp_q       <= 64'h0;
    end else begin
      state_q      <= state_d;
      en_sync_q    <= en_sync_d;
      ack_sync_q   <= ack_sync_d;
      acc_en_ack_q <= acc_en_ack_d;
      rd_req_q     <= rd_req_d;
      wr_req_q     <= wr_req_d;
      mst_addr_q   <= mst_addr_d;
      mst_be_q     <= mst_be_d;
      mst_wdata_q  <= mst_wdata_d;
      cap_addr_q   <= cap_addr_d;
      cap_data_q   <= cap_data_d;
      cap_be_q     <= cap_be_d;
      cap_wr_q     <= cap_wr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      tout_q       <= tout_d;
      wdone_q      <= wdone_d;
      rdone_q      <= rdone_d;
      cmplt_q      <= cmplt_d;
      rdata_q      <= rdata_d;
      drv_q        <= drv_d;
      snd_resp_q   <= snd_resp_d;
      resp_q       <= resp_d;
    end
  end

  assign acc_en_ack           = acc_en_ack_q;
  assign bus.IP2Bus_MstRd_Req = rd_req_q;
  assign bus.IP2Bus_MstWr_Req = wr_req_q;
  assign bus.IP2Bus_Mst_Addr  = mst_addr_q;
  assign bus.IP2Bus_Mst_BE    = mst_be_q;
  assign bus.IP2Bus_MstWr_d   = mst_wdata_q;
  assign drv_regif            = drv_q;
  assign snd_resp             = snd_resp_q;
  assign resp                 = resp_q;
endmodule

// File: tb/tb_regif_rw_acc.sv
// Directed bench for regif_rw_acc: drives host requests and a scripted REGIF bus, checks responses.
module tb_regif_rw_acc;
  localparam int TOUT = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] acc_addr;
  logic [31:0] acc_data;
  logic [3:0]  acc_be;
  logic        acc_wr;
  logic        acc_en;
  logic        acc_en_ack;
  logic        snd_resp;
  logic        snd_resp_ack;
  logic [63:0] resp;
  logic        my_regif;
  logic        drv_regif;
  int          n_tests;
  int          n_fail;
  int          ack_total;

  regif_rw_acc_if bus_if ();

  regif_rw_acc #(.TIMEOUT_CYCLES(TOUT), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .acc_addr     (acc_addr),
    .acc_data     (acc_data),
    .acc_be       (acc_be),
    .acc_wr       (acc_wr),
    .acc_en       (acc_en),
    .acc_en_ack   (acc_en_ack),
    .bus          (bus_if),
    .snd_resp     (snd_resp),
    .snd_resp_ack (snd_resp_ack),
    .resp         (resp),
    .my_regif     (my_regif),
    .drv_regif    (drv_regif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accept pulses, sampled away from the active edge.
  always @(negedge clk) if (acc_en_ack) ack_total <= ack_total + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus_if.Bus2IP_Mst_CmdAck      = 1'b0;
    bus_if.Bus2IP_Mst_Cmplt       = 1'b0;
    bus_if.Bus2IP_Mst_Error       = 1'b0;
    bus_if.Bus2IP_MstWr_dst_rdy_n = 1'b1;
    bus_if.Bus2IP_MstRd_src_rdy_n = 1'b1;
    bus_if.Bus2IP_MstRd_d         = 32'h0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!(bus_if.IP2Bus_MstRd_Req || bus_if.IP2Bus_MstWr_Req) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_req_seen"}, 64'(bus_if.IP2Bus_MstRd_Req | bus_if.IP2Bus_MstWr_Req), 64'h1);
  endtask

  // mode: 0 same-cycle completion, 1 read data two cycles before Cmplt, 2 Cmplt with Error, 3 silent bus
  task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input int mode, input int gdelay, input int hold,
                           input logic [63:0] exp_resp, input string tag);
    int n;
    int ack_start;
    ack_start = ack_total;
    acc_addr  = addr;
    acc_data  = wr ? data : 32'hFFFF_0000;
    acc_be    = be;
    acc_wr    = wr;
    my_regif  = (gdelay == 0);
    acc_en    = 1'b1;
    if (gdelay > 0) begin
      repeat (gdelay + 4) @(negedge clk);
      check_val({tag, "_nodrv"}, 64'(drv_regif), 64'h0);
      my_regif = 1'b1;
    end
    wait_req(tag);
    check_val({tag, "_reqsel"}, 64'({bus_if.IP2Bus_MstWr_Req, bus_if.IP2Bus_MstRd_Req}),
              wr ? 64'h2 : 64'h1);
    check_val({tag, "_addr"}, 64'(bus_if.IP2Bus_Mst_Addr), 64'(addr));
    check_val({tag, "_be"}, 64'(bus_if.IP2Bus_Mst_BE), 64'(be));
    if (wr) check_val({tag, "_wd"}, 64'(bus_if.IP2Bus_MstWr_d), 64'(data));
    if (mode == 3) begin
      n = 0;
      while ((bus_if.IP2Bus_MstRd_Req || bus_if.IP2Bus_MstWr_Req) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check_val({tag, "_req_cycles"}, 64'(n), 64'(TOUT - 1));
    end else begin
      bus_if.Bus2IP_Mst_CmdAck = 1'b1;
      if (wr) bus_if.Bus2IP_MstWr_dst_rdy_n = 1'b0;
      else begin
        bus_if.Bus2IP_MstRd_src_rdy_n = 1'b0;
        bus_if.Bus2IP_MstRd_d         = data;
      end
      bus_if.Bus2IP_Mst_Cmplt = (mode != 1);
      bus_if.Bus2IP_Mst_Error = (mode == 2);
      @(negedge clk);
      bus_idle();
      check_val({tag, "_req_drop"}, 64'(bus_if.IP2Bus_MstRd_Req | bus_if.IP2Bus_MstWr_Req), 64'h0);
      if (mode == 1) begin
        @(negedge clk);
        bus_if.Bus2IP_Mst_Cmplt = 1'b1;
        @(negedge clk);
        bus_idle();
      end
    end
    n = 0;
    while (!snd_resp && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_snd"}, 64'(snd_resp), 64'h1);
    check_val({tag, "_drv_low"}, 64'(drv_regif), 64'h0);
    check_val({tag, "_resp"}, resp, exp_resp);
    if (mode == 3) begin
      bus_if.Bus2IP_Mst_Cmplt       = 1'b1;
      bus_if.Bus2IP_MstWr_dst_rdy_n = 1'b0;
      @(negedge clk);
      bus_idle();
      @(negedge clk);
      check_val({tag, "_late_resp"}, resp, exp_resp);
    end
    snd_resp_ack = 1'b1;
    n = 0;
    while (snd_resp && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_snd_drop"}, 64'(snd_resp), 64'h0);
    snd_resp_ack = 1'b0;
    repeat (hold) @(negedge clk);
    acc_en = 1'b0;
    repeat (8) @(negedge clk);
    check_val({tag, "_one_ack"}, 64'(ack_total - ack_start), 64'h1);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    ack_total    = 0;
    rst_n        = 1'b0;
    acc_addr     = 32'h0;
    acc_data     = 32'h0;
    acc_be       = 4'h0;
    acc_wr       = 1'b0;
    acc_en       = 1'b0;
    snd_resp_ack = 1'b0;
    my_regif     = 1'b0;
    bus_idle();
    repeat (3) @(negedge clk);
    check_val("rst_ack", 64'(acc_en_ack), 64'h0);
    check_val("rst_reqs", 64'({bus_if.IP2Bus_MstWr_Req, bus_if.IP2Bus_MstRd_Req}), 64'h0);
    check_val("rst_be", 64'(bus_if.IP2Bus_Mst_BE), 64'h0);
    check_val("rst_drv", 64'(drv_regif), 64'h0);
    check_val("rst_snd", 64'(snd_resp), 64'h0);
    check_val("rst_resp", resp, 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_access(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 64'h00000001_DEADBEEF, "wr");
    do_access(1'b0, 32'h0000_2004, 32'h1234_5678, 4'h3, 1, 0, 0, 64'h00000001_12345678, "rd");
    do_access(1'b1, 32'h0000_3008, 32'hCAFE_F00D, 4'hC, 2, 3, 0, 64'h00000002_CAFEF00D, "err");
    do_access(1'b1, 32'h0000_400C, 32'h5555_AAAA, 4'hF, 3, 0, 0, 64'h00000003_00000000, "tout");

    // A stray completion with nothing outstanding must not produce a response.
    bus_if.Bus2IP_Mst_Cmplt        = 1'b1;
    bus_if.Bus2IP_MstRd_src_rdy_n  = 1'b0;
    @(negedge clk);
    bus_idle();
    repeat (4) @(negedge clk);
    check_val("idle_cmplt_snd", 64'(snd_resp), 64'h0);

    do_access(1'b0, 32'h0000_5010, 32'hA5A5_5A5A, 4'h1, 0, 0, 10, 64'h00000001_A5A55A5A, "hold");

    // Reset in the middle of a bus access.
    acc_addr = 32'h0000_6000;
    acc_data = 32'h0BAD_F00D;
    acc_be   = 4'hF;
    acc_wr   = 1'b1;
    my_regif = 1'b1;
    acc_en   = 1'b1;
    wait_req("rst");
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_req", 64'(bus_if.IP2Bus_MstWr_Req | bus_if.IP2Bus_MstRd_Req), 64'h0);
    check_val("rst_mid_drv", 64'(drv_regif), 64'h0);
    check_val("rst_mid_snd", 64'(snd_resp), 64'h0);
    acc_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_mid_resp", resp, 64'h0);
    do_access(1'b0, 32'h0000_7000, 32'h0F0F_1234, 4'hF, 0, 0, 0, 64'h00000001_0F0F1234, "post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
